// File: rtl/ycr_jtag_scan_master.sv
// ycr_jtag_scan_master: JTAG scan initiator that walks a TAP through one IR or DR scan per request.
// Shifts req_data LSB first on TDI and returns the TDO bits captured on each TCK rise, LSB first.
module ycr_jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int CLK_DIV = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_is_ir_i,
    input  logic [5:0]         req_len_i,
    input  logic [MAX_LEN-1:0] req_data_i,
    output logic               rsp_valid_o,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    input  logic               tdo_i
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {TLR_SEQ, IDLE, HDR, SHIFT, TRL, DONE} state_e;

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d, len_q, len_d, steps;
    logic [DW-1:0]      div_q, div_d;
    logic               tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
    logic               is_ir_q, is_ir_d, err_q, err_d;
    logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d, tdi_sh;
    logic               rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic               active, rise, step_end, accept, bad_len;

    always_comb begin
        active = state_q inside {TLR_SEQ, HDR, SHIFT, TRL};
        rise = active && !tck_q && div_q == DIV_LAST;
        step_end = active && tck_q && div_q == DIV_LAST;
        accept = state_q == IDLE && req_valid_i;
        bad_len = req_len_i == 6'd0 || {26'd0, req_len_i} > 32'(MAX_LEN);
        steps = state_q == TLR_SEQ ? 6'd6 :
                state_q == HDR     ? (is_ir_q ? 6'd4 : 6'd3) :
                state_q == SHIFT   ? len_q : 6'd2;
        state_d = state_q;
        cnt_d = cnt_q;
        len_d = len_q;
        is_ir_d = is_ir_q;
        data_d = data_q;
        err_d = err_q;
        cap_d = cap_q;
        div_d = active && div_q != DIV_LAST ? div_q + DW'(1) : '0;
        tck_d = active && (div_q == DIV_LAST ? !tck_q : tck_q);
        if (accept) begin
            len_d = req_len_i;
            is_ir_d = req_is_ir_i;
            data_d = req_data_i;
            err_d = bad_len;
            cap_d = '0;
            cnt_d = '0;
            state_d = bad_len ? DONE : HDR;
        end
        // TDO enters at the top of the scan window so the result ends right-aligned
        if (state_q == SHIFT && rise)
            cap_d = (cap_q >> 1) | ({{(MAX_LEN-1){1'b0}}, tdo_i} << (len_q - 6'd1));
        if (step_end) begin
            cnt_d = cnt_q == steps - 6'd1 ? 6'd0 : cnt_q + 6'd1;
            if (cnt_q == steps - 6'd1)
                state_d = state_q == TLR_SEQ ? IDLE :
                          state_q == HDR     ? SHIFT :
                          state_q == SHIFT   ? TRL : DONE;
        end
        if (state_q == DONE)
            state_d = IDLE;
        rsp_valid_d = state_q == DONE;
        rsp_data_d = state_q == DONE ? cap_q : rsp_data_q;
        rsp_err_d = state_q == DONE ? err_q : rsp_err_q;
        // TMS/TDI follow the next bit position, which only moves at a TCK fall or on accept
        tdi_sh = data_d >> cnt_d;
        tms_d = state_d == TLR_SEQ ? cnt_d < 6'd5 :
                state_d == HDR     ? cnt_d < (is_ir_d ? 6'd2 : 6'd1) :
                state_d == SHIFT   ? cnt_d == len_d - 6'd1 :
                state_d == TRL     ? cnt_d == 6'd0 : 1'b0;
        tdi_d = state_d == SHIFT && tdi_sh[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TLR_SEQ;
            cnt_q <= '0;
            len_q <= '0;
            div_q <= '0;
            tck_q <= 1'b0;
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
            is_ir_q <= 1'b0;
            err_q <= 1'b0;
            data_q <= '0;
            cap_q <= '0;
            rsp_data_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            len_q <= len_d;
            div_q <= div_d;
            tck_q <= tck_d;
            tms_q <= tms_d;
            tdi_q <= tdi_d;
            is_ir_q <= is_ir_d;
            err_q <= err_d;
            data_q <= data_d;
            cap_q <= cap_d;
            rsp_data_q <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o = rsp_err_q;
    assign tck_o = tck_q;
    assign tms_o = tms_q;
    assign tdi_o = tdi_q;
endmodule

// File: doc/ycr_jtag_scan_master.md
Name: ycr_jtag_scan_master

Overview:
- JTAG scan initiator for the debug subsystem: generates TCK/TMS/TDI and samples TDO to drive a yifive TAP controller from a bench or on-chip debug bridge.
- Accepts one IR-scan or DR-scan request at a time over a valid/ready interface.
- Walks the TAP FSM from Run-Test/Idle through Capture/Shift/Update and back to Run-Test/Idle, then returns the captured TDO bits.
- Acts as the driving end of the TAP data-register shift path: LSB shifted first, TDO captured LSB first.

Parameters:
- MAX_LEN, 32: maximum scan length in bits; width of req_data/rsp_data.
- CLK_DIV, 2: clk cycles per TCK half-period; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  async reset, active-low.
- req_valid  in  1  scan request valid.
- req_ready  out  1  block idle in Run-Test/Idle and able to accept a request.
- req_is_ir  in  1  1 = IR scan, 0 = DR scan.
- req_len  in  6  scan length in bits; legal range 1..MAX_LEN.
- req_data  in  MAX_LEN  TDI data; bit 0 shifted first.
- rsp_valid  out  1  one-clk pulse when a scan completes.
- rsp_data  out  MAX_LEN  captured TDO bits; bit i = TDO sampled while TDI bit i was shifted; bits >= len read 0; held until the next rsp_valid.
- rsp_err  out  1  qualified by rsp_valid; 1 = illegal req_len.
- tck  out  1  JTAG test clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to TAP.
- tdo  in  1  JTAG data from TAP; treated as synchronous to clk.

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0. All state is cleared asynchronously.
- TCK cycle: low phase of CLK_DIV clk cycles, then high phase of CLK_DIV clk cycles. tck=0 whenever no TCK cycle is in progress.
- tms/tdi change only at the start of a low phase (falling edge).
- tdo is sampled in the clk cycle where tck rises.
- States:
  - TLR_SEQ: entered after reset; 5 TCK with tms=1, then 1 TCK with tms=0 to reach Run-Test/Idle.
  - IDLE: req_ready=1, tms=0, tck=0.
  - HDR: header bits. DR = tms 1,0,0. IR = tms 1,1,0,0.
  - SHIFT: len TCKs; tdi=req_data[i]; tms=0 except the last bit, which has tms=1 (Exit1).
  - TRL: tms 1 (Update), then 0 (Run-Test/Idle).
  - DONE: one clk; rsp_valid=1; returns to IDLE.
- Handshake:
  - Request accepted on the clk edge where req_valid & req_ready.
  - req_data, req_len and req_is_ir are latched on that edge; req_ready drops on the following cycle.
  - req_ready goes high again in the cycle after DONE.
- Latency: K TCK cycles, with K = len+5 (DR) or len+6 (IR).
  - rsp_valid asserts exactly 2*CLK_DIV*K + 1 clk cycles after the accept edge.
  - rsp_data is updated in the same cycle as rsp_valid.
- Capture: an internal shift register of width MAX_LEN shifts right with tdo at bit [len-1]. Once the scan finishes, the len captured bits sit right-aligned.
- Illegal length (req_len==0 or req_len>MAX_LEN):
  - Request is accepted with no TCK activity.
  - rsp_valid=1, rsp_err=1, rsp_data=0 on the cycle after accept.
- Back-to-back: a request held valid through DONE is accepted on the first IDLE cycle; there is no TLR between scans.
- rst_n assertion mid-scan: outputs return to reset values immediately. TLR_SEQ reruns after deassertion; no rsp_valid is issued for the aborted scan.
- req_valid is ignored while req_ready=0. There is no back-pressure on rsp.

Test Plan:
- Reset release, CLK_DIV=2 -> 6 TCK cycles of 4 clk each (tms 1,1,1,1,1,0), then req_ready=1; a TAP model reports Run-Test/Idle.
- DR scan, len=8, req_data=0xA5, TAP model with 8-bit DR preloaded 0x3C -> tdi sequence 1,0,1,0,0,1,0,1; rsp_data=0x3C, rsp_err=0; TAP DR holds 0xA5 after Update; rsp_valid at 2*2*13+1=53 clk after accept.
- IR scan, len=5, req_data=0x11 -> tms header 1,1,0,0; TAP IR=0x11; rsp_data equals the TAP IR capture value (0x01); 11 TCK total.
- len=1 DR scan of a 1-bit bypass register preloaded 0, req_data=1 -> single shift TCK with tms=1; rsp_data=0; bypass bit=1 after Update.
- req_len=0 and req_len=40 -> no tck edges, rsp_valid next cycle with rsp_err=1, rsp_data=0.
- rst_n pulsed during SHIFT of a 32-bit DR scan -> tck=0, tms=1 immediately; no rsp_valid; TLR sequence repeats; a following 32-bit scan with tdo looped to tdi through a 32-bit shift register returns the correct data.
